// File: rtl/arp_responder.sv
// rtl/arp_responder.sv - ARP request detector producing a registered reply descriptor
module arp_responder #(
  parameter int CNT_W   = 8,
  parameter int MIN_LEN = 64
) (
  input  logic             i_rx_clk,
  input  logic             rst_n,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_dv,
  input  logic [47:0]      i_local_mac,
  input  logic [31:0]      i_local_ip,
  input  logic             i_enable,
  output logic             o_reply_valid,
  input  logic             i_reply_ack,
  output logic [47:0]      o_dst_mac,
  output logic [47:0]      o_SHA,
  output logic [31:0]      o_SPA,
  output logic [47:0]      o_THA,
  output logic [31:0]      o_TPA,
  output logic [CNT_W-1:0] o_req_count,
  output logic [CNT_W-1:0] o_drop_count
);

  localparam logic [10:0] MIN_LEN_C = 11'(MIN_LEN);
  localparam logic [10:0] CNT_MAX   = 11'h7FF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_HEADER,
    S_TAIL,
    S_DISCARD
  } state_t;

  state_t      state_q;
  logic [10:0] cnt_q;
  logic        bcast_q;
  logic        ucast_q;
  logic        armed_q;   // a dv=0 gap has been seen since reset, so we are frame-aligned
  logic [47:0] sha_q;
  logic [31:0] spa_q;

  logic [7:0]  mac_byte;
  logic        bcast_d;
  logic        ucast_d;
  logic        byte_ok;
  logic        accept;

  // Per-byte header compare against the expected ARP request layout
  always_comb begin
    mac_byte = 8'h00;
    byte_ok  = 1'b1;
    case (cnt_q)
      11'd0:   mac_byte = i_local_mac[47:40];
      11'd1:   mac_byte = i_local_mac[39:32];
      11'd2:   mac_byte = i_local_mac[31:24];
      11'd3:   mac_byte = i_local_mac[23:16];
      11'd4:   mac_byte = i_local_mac[15:8];
      11'd5:   mac_byte = i_local_mac[7:0];
      default: mac_byte = 8'h00;
    endcase
    // Broadcast and unicast matches are tracked separately so a mixed address fails
    bcast_d = (i_rx_data == 8'hFF) && ((cnt_q == 11'd0) || bcast_q);
    ucast_d = (i_rx_data == mac_byte) && ((cnt_q == 11'd0) || ucast_q);
    case (cnt_q)
      11'd0, 11'd1, 11'd2,
      11'd3, 11'd4, 11'd5: byte_ok = bcast_d || ucast_d;
      11'd12:  byte_ok = (i_rx_data == 8'h08);
      11'd13:  byte_ok = (i_rx_data == 8'h06);
      11'd14:  byte_ok = (i_rx_data == 8'h00);
      11'd15:  byte_ok = (i_rx_data == 8'h01);
      11'd16:  byte_ok = (i_rx_data == 8'h08);
      11'd17:  byte_ok = (i_rx_data == 8'h00);
      11'd18:  byte_ok = (i_rx_data == 8'h06);
      11'd19:  byte_ok = (i_rx_data == 8'h04);
      11'd20:  byte_ok = (i_rx_data == 8'h00);
      11'd21:  byte_ok = (i_rx_data == 8'h01);
      11'd38:  byte_ok = (i_rx_data == i_local_ip[31:24]);
      11'd39:  byte_ok = (i_rx_data == i_local_ip[23:16]);
      11'd40:  byte_ok = (i_rx_data == i_local_ip[15:8]);
      11'd41:  byte_ok = (i_rx_data == i_local_ip[7:0]);
      default: byte_ok = 1'b1;
    endcase
    accept = (state_q == S_TAIL) && !i_rx_dv && (cnt_q >= MIN_LEN_C);
  end

  // Receive FSM: preamble hunt, header parse and field capture
  always_ff @(posedge i_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 11'd0;
      bcast_q <= 1'b0;
      ucast_q <= 1'b0;
      armed_q <= 1'b0;
      sha_q   <= 48'h0;
      spa_q   <= 32'h0;
    end else if (!i_rx_dv) begin
      state_q <= S_IDLE;
      armed_q <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!armed_q || !i_enable) state_q <= S_DISCARD;
          else                       state_q <= S_PREAMBLE;
        end
        S_PREAMBLE: begin
          if (i_rx_data == 8'hD5) begin
            state_q <= S_HEADER;
            cnt_q   <= 11'd0;
          end else if (i_rx_data != 8'h55) begin
            state_q <= S_DISCARD;
          end
        end
        S_HEADER: begin
          if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 11'd1;
          bcast_q <= bcast_d;
          ucast_q <= ucast_d;
          if (cnt_q >= 11'd22 && cnt_q <= 11'd27) sha_q <= {sha_q[39:0], i_rx_data};
          if (cnt_q >= 11'd28 && cnt_q <= 11'd31) spa_q <= {spa_q[23:0], i_rx_data};
          if (!byte_ok)                state_q <= S_DISCARD;
          else if (cnt_q == 11'd41)    state_q <= S_TAIL;
        end
        S_TAIL: begin
          if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 11'd1;
        end
        default: state_q <= S_DISCARD;
      endcase
    end
  end

  // Reply descriptor handshake and request/drop accounting
  always_ff @(posedge i_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      o_reply_valid <= 1'b0;
      o_dst_mac     <= 48'h0;
      o_SHA         <= 48'h0;
      o_SPA         <= 32'h0;
      o_THA         <= 48'h0;
      o_TPA         <= 32'h0;
      o_req_count   <= '0;
      o_drop_count  <= '0;
    end else if (accept && (!o_reply_valid || i_reply_ack)) begin
      o_reply_valid <= 1'b1;
      o_dst_mac     <= sha_q;
      o_SHA         <= i_local_mac;
      o_SPA         <= i_local_ip;
      o_THA         <= sha_q;
      o_TPA         <= spa_q;
      o_req_count   <= o_req_count + 1'b1;
    end else begin
      if (accept)      o_drop_count  <= o_drop_count + 1'b1;
      if (i_reply_ack) o_reply_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arp_responder.sv
// tb/tb_arp_responder.sv - randomized self-checking bench for arp_responder
module tb_arp_responder;

  localparam int CNT_W   = 4;
  localparam int MIN_LEN = 64;
  localparam logic [47:0] MAC = 48'h02AA_BBCC_DDEE;
  localparam logic [31:0] IP  = 32'hC0A8_0001;

  logic             clk;
  logic             rst_n;
  logic [7:0]       rx_data;
  logic             rx_dv;
  logic             enable;
  logic             reply_ack;
  logic             reply_valid;
  logic [47:0]      dst_mac, sha_o, tha_o;
  logic [31:0]      spa_o, tpa_o;
  logic [CNT_W-1:0] req_count, drop_count;

  arp_responder #(.CNT_W(CNT_W), .MIN_LEN(MIN_LEN)) dut (
    .i_rx_clk      (clk),
    .rst_n         (rst_n),
    .i_rx_data     (rx_data),
    .i_rx_dv       (rx_dv),
    .i_local_mac   (MAC),
    .i_local_ip    (IP),
    .i_enable      (enable),
    .o_reply_valid (reply_valid),
    .i_reply_ack   (reply_ack),
    .o_dst_mac     (dst_mac),
    .o_SHA         (sha_o),
    .o_SPA         (spa_o),
    .o_THA         (tha_o),
    .o_TPA         (tpa_o),
    .o_req_count   (req_count),
    .o_drop_count  (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_pass;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // reference model of the reply descriptor and counters
  logic             m_valid;
  logic [47:0]      m_dst, m_sha, m_tha;
  logic [31:0]      m_spa, m_tpa;
  logic [CNT_W-1:0] m_req, m_drop;

  logic [7:0] fr[$];

  task automatic model_reset();
    m_valid = 1'b0; m_dst = '0; m_sha = '0; m_tha = '0; m_spa = '0; m_tpa = '0;
    m_req = '0; m_drop = '0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 64'(reply_valid), 64'(m_valid));
    chk({tag, ".dst"},   64'(dst_mac),     64'(m_dst));
    chk({tag, ".sha"},   64'(sha_o),       64'(m_sha));
    chk({tag, ".spa"},   64'(spa_o),       64'(m_spa));
    chk({tag, ".tha"},   64'(tha_o),       64'(m_tha));
    chk({tag, ".tpa"},   64'(tpa_o),       64'(m_tpa));
    chk({tag, ".req"},   64'(req_count),   64'(m_req));
    chk({tag, ".drop"},  64'(drop_count),  64'(m_drop));
  endtask

  task automatic build(input logic [47:0] dst, input logic [15:0] oper, input logic [47:0] sha,
                       input logic [31:0] spa, input logic [31:0] tpa, input int len);
    logic [8*42-1:0] hdr;
    hdr = {dst, 48'h0A0B_0C0D_0E0F, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04,
           oper, sha, spa, 48'h0, tpa};
    fr.delete();
    for (int i = 0; i < len; i++) begin
      if (i < 42) fr.push_back(hdr[8*(41-i) +: 8]);
      else        fr.push_back(8'($urandom));
    end
  endtask

  function automatic logic [63:0] field(input int first, input int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[55:0], fr[first+i]};
    return v;
  endfunction

  // ARP request for this station, judged from the frame contents alone
  function automatic bit frame_ok();
    if (fr.size() < MIN_LEN || fr.size() < 42) return 1'b0;
    if (field(0, 6) != 64'hFFFF_FFFF_FFFF && field(0, 6) != 64'(MAC)) return 1'b0;
    if (field(12, 2) != 64'h0806 || field(14, 2) != 64'h0001) return 1'b0;
    if (field(16, 2) != 64'h0800 || field(18, 1) != 64'h06 || field(19, 1) != 64'h04) return 1'b0;
    if (field(20, 2) != 64'h0001) return 1'b0;
    return field(38, 4) == 64'(IP);
  endfunction

  task automatic send(input string tag, input bit en, input bit ack, input int rst_at);
    bit was_reset = 1'b0;
    bit ok;
    ok = en && frame_ok();
    @(negedge clk);
    enable = en; rx_dv = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_data = (i == 7) ? 8'hD5 : 8'h55;
      @(negedge clk);
    end
    for (int i = 0; i < fr.size(); i++) begin
      if (was_reset && i == rst_at + 1) begin
        check_all({tag, ".rst"});
        rst_n = 1'b1;
      end
      rx_data = fr[i];
      if (i == rst_at) begin
        rst_n = 1'b0;
        was_reset = 1'b1;
        model_reset();
      end
      @(negedge clk);
    end
    chk({tag, ".early"}, 64'(reply_valid), 64'(m_valid));
    rx_dv = 1'b0; reply_ack = ack;
    @(negedge clk);
    reply_ack = 1'b0;
    if (ok && !was_reset) begin
      if (!m_valid || ack) begin
        m_valid = 1'b1; m_dst = field(22, 6); m_tha = field(22, 6);
        m_sha = MAC; m_spa = IP; m_tpa = field(28, 4);
        m_req = m_req + 1'b1;
      end else begin
        m_drop = m_drop + 1'b1;
      end
    end else if (ack) begin
      m_valid = 1'b0;
    end
    check_all(tag);
  endtask

  task automatic ack_only();
    @(negedge clk); reply_ack = 1'b1;
    @(negedge clk); reply_ack = 1'b0;
    m_valid = 1'b0;
    chk("ack.valid", 64'(reply_valid), 64'(m_valid));
  endtask

  localparam logic [47:0] BC = 48'hFFFF_FFFF_FFFF;

  initial begin
    logic [47:0] sha;
    logic [31:0] spa;
    int kind;
    n_checks = 0; n_pass = 0;
    rst_n = 1'b0; rx_dv = 1'b0; rx_data = 8'h00; enable = 1'b1; reply_ack = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    build(BC, 16'h0001, 48'h0011_2233_4455, 32'hC0A8_0002, IP, 64);
    send("basic", 1'b1, 1'b0, -1);
    chk("basic.tha_abs", 64'(tha_o), 64'h0011_2233_4455);
    chk("basic.tpa_abs", 64'(tpa_o), 64'hC0A8_0002);
    ack_only();

    build(BC, 16'h0001, 48'h0011_2233_4455, 32'hC0A8_0002, 32'hC0A8_0009, 64);
    send("wrong_tpa", 1'b1, 1'b0, -1);
    build(BC, 16'h0002, 48'h0011_2233_4455, 32'hC0A8_0002, IP, 64);
    send("reply_oper", 1'b1, 1'b0, -1);

    build(BC, 16'h0001, 48'h0000_0000_0A01, 32'h0A00_0001, IP, 64);
    send("first", 1'b1, 1'b0, -1);
    build(BC, 16'h0001, 48'h0000_0000_0A02, 32'h0A00_0002, IP, 70);
    send("dropped", 1'b1, 1'b0, -1);
    build(BC, 16'h0001, 48'h0000_0000_0A03, 32'h0A00_0003, IP, 64);
    send("ack_reload", 1'b1, 1'b1, -1);
    ack_only();

    build(BC, 16'h0001, 48'h0000_0000_0B01, 32'h0B00_0001, IP, 50);
    send("short50", 1'b1, 1'b0, -1);
    build(BC, 16'h0001, 48'h0000_0000_0B02, 32'h0B00_0002, IP, 30);
    send("cut30", 1'b1, 1'b0, -1);
    build(BC, 16'h0001, 48'h0000_0000_0B03, 32'h0B00_0003, IP, 64);
    send("after_short", 1'b1, 1'b0, -1);

    build(BC, 16'h0001, 48'h0000_0000_0C01, 32'h0C00_0001, IP, 64);
    send("mid_reset", 1'b1, 1'b0, 25);
    build(BC, 16'h0001, 48'h0000_0000_0C02, 32'h0C00_0002, IP, 64);
    send("after_reset", 1'b1, 1'b0, -1);
    ack_only();

    for (int n = 0; n < 200; n++) begin
      sha = {16'($urandom), 32'($urandom)};
      spa = 32'($urandom);
      kind = $urandom_range(0, 10);
      case (kind)
        3:  build(BC, 16'h0001, sha, spa, IP ^ (32'h1 << $urandom_range(0, 31)), 64);
        4:  build(BC, 16'h0002, sha, spa, IP, 64);
        5:  build(BC, 16'h0001, sha, spa, IP, $urandom_range(42, MIN_LEN - 1));
        6:  build(MAC, 16'h0001, sha, spa, IP, 64);
        7:  build({16'($urandom), 32'($urandom)}, 16'h0001, sha, spa, IP, 64);
        8:  build({16'hFFFF, MAC[31:0]}, 16'h0001, sha, spa, IP, 64);
        9:  build(BC, 16'h0001, sha, spa, IP, $urandom_range(1, 41));
        10: build(BC, 16'h0001, sha, spa, IP, MIN_LEN);
        default: build(BC, 16'h0001, sha, spa, IP, $urandom_range(MIN_LEN, 100));
      endcase
      send("rand", ($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), -1);
      if ($urandom_range(0, 3) == 0) ack_only();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
